// File: rtl/if_fetch_unit.sv
// ============================================================================
// if_fetch_unit
// ----------------------------------------------------------------------------
// Instruction-fetch stage feeding the decoder. Owns the PC, issues one fetch
// at a time to instruction memory over a req/gnt/rvalid handshake, and drives
// a registered pc/inst/valid triple to the decode stage. A downstream stall
// parks a returning instruction in a one-entry hold buffer. A flush redirects
// the PC and discards whatever fetch is still outstanding.
//
// Ports
//   clk            in   1   clock, all state on rising edge
//   Rst_n          in   1   asynchronous active-low reset
//   imem_req_o     out  1   fetch request, held until imem_gnt_i
//   imem_addr_o    out  32  fetch address (current PC)
//   imem_gnt_i     in   1   request accepted this cycle
//   imem_rvalid_i  in   1   read data valid, one per grant
//   imem_rdata_i   in   32  instruction word
//   stall_i        in   1   decode cannot accept; hold outputs
//   flush_i        in   1   redirect; discard in-flight fetch
//   flush_pc_i     in   32  redirect target (low two bits ignored)
//   pc_o           out  32  PC of inst_o
//   inst_o         out  32  instruction to decode (32'h0 = bubble)
//   inst_valid_o   out  1   inst_o holds a real fetched instruction
// ============================================================================
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        Rst_n,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        inst_valid_o
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      HOLD = 3'd3,
      DROP = 3'd4
   } state_t;

   state_t      state_q,    state_d;
   logic [31:0] pc_q,       pc_d;
   logic [31:0] buf_pc_q,   buf_pc_d;
   logic [31:0] buf_inst_q, buf_inst_d;
   logic [31:0] out_pc_q,   out_pc_d;
   logic [31:0] out_inst_q, out_inst_d;
   logic        out_vld_q,  out_vld_d;

   // Word-aligned successor address; wraps silently at the top of memory.
   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   // Next-state, PC, hold buffer and output register computation.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      buf_pc_d   = buf_pc_q;
      buf_inst_d = buf_inst_q;
      // With nothing new to present: keep outputs under stall, else bubble.
      out_pc_d   = out_pc_q;
      if (stall_i) begin
         out_inst_d = out_inst_q;
         out_vld_d  = out_vld_q;
      end else begin
         out_inst_d = 32'h0000_0000;
         out_vld_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            state_d = REQ;
         end
         REQ: begin
            if (imem_gnt_i) begin
               state_d = WAIT;
            end else begin
               state_d = REQ;
            end
         end
         WAIT: begin
            if (imem_rvalid_i) begin
               pc_d = next_pc(pc_q);
               if (stall_i) begin
                  buf_pc_d   = pc_q;
                  buf_inst_d = imem_rdata_i;
                  state_d    = HOLD;
               end else begin
                  out_pc_d   = pc_q;
                  out_inst_d = imem_rdata_i;
                  out_vld_d  = 1'b1;
                  state_d    = REQ;
               end
            end else begin
               state_d = WAIT;
            end
         end
         HOLD: begin
            if (!stall_i) begin
               out_pc_d   = buf_pc_q;
               out_inst_d = buf_inst_q;
               out_vld_d  = 1'b1;
               state_d    = REQ;
            end else begin
               state_d = HOLD;
            end
         end
         DROP: begin
            // The stale response is consumed here and never reaches decode.
            if (imem_rvalid_i) begin
               state_d = REQ;
            end else begin
               state_d = DROP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Redirect overrides everything above. A fetch that has been granted
      // but whose data has not yet returned must be drained in DROP.
      if (flush_i) begin
         pc_d       = {flush_pc_i[31:2], 2'b00};
         buf_pc_d   = 32'h0000_0000;
         buf_inst_d = 32'h0000_0000;
         out_pc_d   = out_pc_q;
         out_inst_d = 32'h0000_0000;
         out_vld_d  = 1'b0;
         if (((state_q == REQ) && imem_gnt_i) ||
             (((state_q == WAIT) || (state_q == DROP)) && !imem_rvalid_i)) begin
            state_d = DROP;
         end else begin
            state_d = REQ;
         end
      end else begin
         state_d = state_d;
      end
   end

   // State, PC, hold buffer and output register flops.
   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         buf_pc_q   <= 32'h0000_0000;
         buf_inst_q <= 32'h0000_0000;
         out_pc_q   <= 32'h0000_0000;
         out_inst_q <= 32'h0000_0000;
         out_vld_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         buf_pc_q   <= buf_pc_d;
         buf_inst_q <= buf_inst_d;
         out_pc_q   <= out_pc_d;
         out_inst_q <= out_inst_d;
         out_vld_q  <= out_vld_d;
      end
   end

   assign imem_req_o   = (state_q == REQ);
   assign imem_addr_o  = pc_q;
   assign pc_o         = out_pc_q;
   assign inst_o       = out_inst_q;
   assign inst_valid_o = out_vld_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// tb_if_fetch_unit
// ----------------------------------------------------------------------------
// Directed bench for if_fetch_unit. Inputs change 1 time unit after a rising
// edge and outputs are sampled at that same point, so every check observes
// state settled well away from the next active edge.
// ============================================================================
`timescale 1ns/1ps
module tb_if_fetch_unit;

   logic        clk;
   logic        Rst_n;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        stall_i;
   logic        flush_i;
   logic [31:0] flush_pc_i;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        inst_valid_o;

   int n_checks = 0;
   int n_pass   = 0;

   if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .Rst_n         (Rst_n),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .stall_i       (stall_i),
      .flush_i       (flush_i),
      .flush_pc_i    (flush_pc_i),
      .pc_o          (pc_o),
      .inst_o        (inst_o),
      .inst_valid_o  (inst_valid_o)
   );

   // Free-running clock, 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic gnt, input logic rv, input logic [31:0] rd,
                         input logic st, input logic fl, input logic [31:0] fpc);
      imem_gnt_i    = gnt;
      imem_rvalid_i = rv;
      imem_rdata_i  = rd;
      stall_i       = st;
      flush_i       = fl;
      flush_pc_i    = fpc;
   endtask

   task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                            input logic vld);
      check_val({tag, "_pc"},   pc_o, pc);
      check_val({tag, "_inst"}, inst_o, inst);
      check_val({tag, "_vld"},  {31'd0, inst_valid_o}, {31'd0, vld});
   endtask

   task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
      check_val({tag, "_req"},  {31'd0, imem_req_o}, {31'd0, req});
      check_val({tag, "_addr"}, imem_addr_o, addr);
   endtask

   initial begin
      Rst_n = 1'b0;
      set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      tick();
      // Reset state
      check_out("rst", 32'h0, 32'h0, 1'b0);
      check_req("rst", 1'b0, 32'h0);

      Rst_n = 1'b1;
      tick();                                          // IDLE -> REQ
      check_req("first_req", 1'b1, 32'h0);

      // 1: grant with request, data next cycle
      set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();                                          // -> WAIT
      check_req("t1_wait", 1'b0, 32'h0);
      set_in(1'b0, 1'b1, 32'h3401_0001, 1'b0, 1'b0, 32'h0);
      tick();                                          // load output, -> REQ
      check_out("t1_out", 32'h0, 32'h3401_0001, 1'b1);
      check_req("t1_next", 1'b1, 32'h4);

      // 2: withhold grant 3 cycles, plus a stray rvalid in REQ (ignored)
      set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         if (i == 1) imem_rvalid_i = 1'b1;
         else        imem_rvalid_i = 1'b0;
         tick();
         check_req("t2_hold", 1'b1, 32'h4);
         check_out("t2_bub", 32'h0, 32'h0, 1'b0);
      end

      // 3: fetch pc 4, then stall while pc 8 returns
      set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      set_in(1'b0, 1'b1, 32'hA000_0004, 1'b0, 1'b0, 32'h0);
      tick();
      check_out("t3_pc4", 32'h4, 32'hA000_0004, 1'b1);
      set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tick();                                          // -> WAIT, outputs held
      check_out("t3_held0", 32'h4, 32'hA000_0004, 1'b1);
      set_in(1'b0, 1'b1, 32'hA000_0008, 1'b1, 1'b0, 32'h0);
      tick();                                          // buffered, -> HOLD
      check_out("t3_held1", 32'h4, 32'hA000_0004, 1'b1);
      set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tick();
      check_out("t3_held2", 32'h4, 32'hA000_0004, 1'b1);
      check_req("t3_hold", 1'b0, 32'hC);
      stall_i = 1'b0;
      tick();                                          // buffer released
      check_out("t3_pc8", 32'h8, 32'hA000_0008, 1'b1);
      check_req("t3_next", 1'b1, 32'hC);
      tick();
      check_out("t3_once", 32'h8, 32'h0, 1'b0);

      // 4: flush in WAIT, stale rvalid discarded
      set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();                                          // -> WAIT
      set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
      tick();                                          // -> DROP
      check_out("t4_bub", 32'h8, 32'h0, 1'b0);
      check_req("t4_drop", 1'b0, 32'h100);
      set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      check_req("t4_drop2", 1'b0, 32'h100);
      set_in(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
      tick();                                          // stale data dropped
      check_out("t4_disc", 32'h8, 32'h0, 1'b0);
      check_req("t4_req", 1'b1, 32'h100);

      // 5: flush coincident with rvalid, under stall
      set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      set_in(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b1, 32'h0000_0200);
      tick();
      check_out("t5_bub", 32'h8, 32'h0, 1'b0);
      check_req("t5_req", 1'b1, 32'h200);

      // PC wrap at top of address space
      set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
      tick();                                          // REQ w/o gnt -> REQ
      check_req("wrap_req", 1'b1, 32'hFFFF_FFFC);
      set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      set_in(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
      tick();
      check_out("wrap_out", 32'hFFFF_FFFC, 32'h1234_5678, 1'b1);
      check_req("wrap_next", 1'b1, 32'h0);

      // 6: async reset mid-WAIT with pc moved away from RESET_PC
      set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0040);
      tick();
      set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();                                          // -> WAIT
      set_in(1'b0, 1'b1, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0);
      tick();
      check_out("t6_pre", 32'h40, 32'h5555_AAAA, 1'b1);
      set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();                                          // -> WAIT
      set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      #2;
      Rst_n = 1'b0;
      #1;                                              // no clock edge in between
      check_out("t6_rst", 32'h0, 32'h0, 1'b0);
      check_req("t6_rst", 1'b0, 32'h0);
      tick();
      Rst_n = 1'b1;
      tick();
      check_req("t6_restart", 1'b1, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
